// File: rtl/demux_strobe_seq_if.sv
// Beat handshake bundle for the demux strobe sequencer.
// The master offers (data, dest) beats; the slave answers with ready.
interface demux_strobe_seq_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_data;
   logic [3:0] in_dest;
   logic       scan_en;

   modport master (
      output in_valid,
      output in_data,
      output in_dest,
      output scan_en,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_dest,
      input  scan_en,
      output in_ready
   );
endinterface

// File: rtl/demux_strobe_seq.sv
// Sequencer for a 1x16 demux: select settles one cycle before strobe,
// with a shadow of each channel's last written value and a scan pointer.
module demux_strobe_seq #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux_strobe_seq_if.slave    bus,
   output logic [3:0]           s,
   output logic                 i,
   output logic [15:0]          ch_state,
   output logic                 wrap
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRIVE
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  hold_q, hold_d;
   logic [3:0]  s_q, s_d;
   logic [3:0]  ptr_q, ptr_d;
   logic        data_q, data_d;
   logic        i_q, i_d;
   logic        wrap_q, wrap_d;
   logic [15:0] ch_q, ch_d;
   logic        accept;
   logic [3:0]  pick;

   assign bus.in_ready = (state_q == IDLE) && rst_n;
   assign accept       = bus.in_valid && bus.in_ready;
   assign pick         = bus.scan_en ? ptr_q : bus.in_dest;

   assign s        = s_q;
   assign i        = i_q;
   assign ch_state = ch_q;
   assign wrap     = wrap_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         s_q     <= '0;
         ptr_q   <= '0;
         data_q  <= 1'b0;
         i_q     <= 1'b0;
         wrap_q  <= 1'b0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         s_q     <= s_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         i_q     <= i_d;
         wrap_q  <= wrap_d;
         ch_q    <= ch_d;
      end
   end

   // s only moves on entry to SETUP, and i only moves on DRIVE entry/exit,
   // so the two never change on the same edge.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      s_d     = s_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      i_d     = i_q;
      wrap_d  = 1'b0;
      ch_d    = ch_q;
      unique case (state_q)
         IDLE: begin
            i_d = 1'b0;
            if (accept) begin
               data_d  = bus.in_data;
               s_d     = pick;
               state_d = SETUP;
               if (bus.scan_en) begin
                  ptr_d  = ptr_q + 4'd1;
                  wrap_d = (ptr_q == 4'd15);
               end
            end
         end
         SETUP: begin
            i_d     = data_q;
            hold_d  = HOLD_LAST;
            state_d = DRIVE;
         end
         DRIVE: begin
            if (hold_q == 4'd0) begin
               i_d       = 1'b0;
               ch_d[s_q] = data_q;
               state_d   = IDLE;
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         default: begin
            i_d     = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_demux_strobe_seq.sv
// Directed plus randomized bench for demux_strobe_seq against a
// beat-level model of select, strobe, shadow and scan pointer.
module tb_demux_strobe_seq;
   localparam int HOLD = 2;

   logic        clk;
   logic        rst_n;
   logic [3:0]  s;
   logic        i;
   logic [15:0] ch_state;
   logic        wrap;

   demux_strobe_seq_if vif ();

   demux_strobe_seq #(.HOLD_CYCLES(HOLD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (vif),
      .s        (s),
      .i        (i),
      .ch_state (ch_state),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_ch;
   logic [3:0]  exp_ptr;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_ch  = '0;
      exp_ptr = '0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      vif.in_valid = 1'b1;
      vif.in_data  = 1'b1;
      vif.in_dest  = 4'd7;
      vif.scan_en  = 1'b0;
      #1;
      chk("rst_ready", 16'(vif.in_ready), 16'd0);
      repeat (2) begin
         tick();
         chk("rst_ready", 16'(vif.in_ready), 16'd0);
         chk("rst_s", 16'(s), 16'd0);
         chk("rst_i", 16'(i), 16'd0);
         chk("rst_ch", ch_state, 16'h0000);
         chk("rst_wrap", 16'(wrap), 16'd0);
      end
      rst_n        = 1'b1;
      vif.in_valid = 1'b0;
      model_reset();
      tick();
      chk("post_rst_ready", 16'(vif.in_ready), 16'd1);
      chk("post_rst_s", 16'(s), 16'd0);
   endtask

   // One full beat: offered in an IDLE cycle, followed cycle by cycle.
   task automatic beat(input logic d, input logic [3:0] dst,
                       input logic sc, input bit keep);
      logic [3:0] ed;
      logic       ew;
      vif.in_valid = 1'b1;
      vif.in_data  = d;
      vif.in_dest  = dst;
      vif.scan_en  = sc;
      #1;
      chk("ready_idle", 16'(vif.in_ready), 16'd1);
      chk("i_idle", 16'(i), 16'd0);
      ed = sc ? exp_ptr : dst;
      ew = sc && (exp_ptr == 4'd15);
      if (sc) exp_ptr = exp_ptr + 4'd1;
      tick();
      vif.in_valid = keep;
      vif.in_data  = 1'($urandom_range(0, 1));
      vif.in_dest  = 4'($urandom_range(0, 15));
      vif.scan_en  = 1'($urandom_range(0, 1));
      chk("setup_s", 16'(s), 16'(ed));
      chk("setup_i", 16'(i), 16'd0);
      chk("setup_ready", 16'(vif.in_ready), 16'd0);
      chk("setup_wrap", 16'(wrap), 16'(ew));
      chk("setup_ch", ch_state, exp_ch);
      for (int h = 0; h < HOLD; h++) begin
         tick();
         chk("drive_s", 16'(s), 16'(ed));
         chk("drive_i", 16'(i), 16'(d));
         chk("drive_ready", 16'(vif.in_ready), 16'd0);
         chk("drive_wrap", 16'(wrap), 16'd0);
      end
      exp_ch[ed] = d;
      tick();
      chk("done_i", 16'(i), 16'd0);
      chk("done_s", 16'(s), 16'(ed));
      chk("done_ch", ch_state, exp_ch);
      chk("done_ready", 16'(vif.in_ready), 16'd1);
   endtask

   initial begin
      rst_n        = 1'b0;
      vif.in_valid = 1'b0;
      vif.in_data  = 1'b0;
      vif.in_dest  = 4'd0;
      vif.scan_en  = 1'b0;
      model_reset();

      // reset holds everything quiet even with valid asserted
      do_reset();

      // addressed beat
      beat(1'b1, 4'd5, 1'b0, 1'b0);
      chk("ch_after_dest5", ch_state, 16'h0020);

      // reset mid-DRIVE discards the beat
      vif.in_valid = 1'b1;
      vif.in_data  = 1'b1;
      vif.in_dest  = 4'd9;
      vif.scan_en  = 1'b0;
      tick();
      vif.in_valid = 1'b0;
      chk("mid_setup_s", 16'(s), 16'd9);
      tick();
      chk("mid_drive_i", 16'(i), 16'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_i", 16'(i), 16'd0);
      chk("mid_rst_s", 16'(s), 16'd0);
      chk("mid_rst_ch", ch_state, 16'h0000);
      chk("mid_rst_ready", 16'(vif.in_ready), 16'd0);
      rst_n = 1'b1;
      model_reset();
      tick();
      chk("mid_rst_idle", 16'(vif.in_ready), 16'd1);
      chk("mid_rst_i2", 16'(i), 16'd0);

      // scan sweep: 17 beats, wrap after the 16th
      for (int n = 0; n < 17; n++)
         beat(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      chk("scan_ch", ch_state, 16'hFFFF);

      // overwrite channel 5 with 1 then 0
      beat(1'b1, 4'd5, 1'b0, 1'b0);
      chk("ow_ch5_set", 16'(ch_state[5]), 16'd1);
      beat(1'b0, 4'd5, 1'b0, 1'b0);
      chk("ow_ch5_clr", 16'(ch_state[5]), 16'd0);

      // back-to-back with valid held high
      beat(1'b1, 4'd3, 1'b0, 1'b1);
      beat(1'b1, 4'd12, 1'b0, 1'b0);

      // randomized beats, mixed scan and addressed
      for (int n = 0; n < 60; n++)
         beat(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      vif.in_valid = 1'b0;
      tick();
      chk("final_ch", ch_state, exp_ch);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
